fetch_pc_ras: RTL and testbench
===============================

# fetch_pc_ras

Parametrised program-counter generator for the fetch stage. It extends the single-target PC register with configurable width, reset vector and increment step, and adds a call/return address stack (RAS) so subroutine returns resolve without an external target. It sits at the front of the pipeline. It drives the instruction-memory address and takes hazard, branch and jump controls from decode/execute.

## Interface
Parameters:
- PC_W, 10, PC width in bits.
- STEP, 1, sequential increment added to pc.
- RESET_PC, 0, value loaded on reset.
- RAS_DEPTH, 4, return-stack entries; must be >= 2.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- stall  in  1  holds pc and RAS unchanged.
- branch  in  1  conditional-branch instruction in execute.
- alu_zero  in  1  branch condition; a branch is taken when branch & alu_zero.
- pc_branch  in  PC_W  branch target.
- jmp  in  1  unconditional jump.
- call  in  1  jump to pc_jmp and push return address pc+STEP.
- ret  in  1  jump to the popped RAS top.
- pc_jmp  in  PC_W  jump/call target; also the fallback ret target.
- pc  out  PC_W  current fetch address (registered).
- ras_count  out  $clog2(RAS_DEPTH+1)  number of valid RAS entries.
- ras_overflow  out  1  one-cycle pulse: a push evicted the oldest entry.
- ras_underflow  out  1  one-cycle pulse: ret with empty RAS.

## Operation
- Next-pc priority, highest first: reset, stall, ret, call, jmp, branch taken, sequential.
- reset: pc <= RESET_PC, ras_count <= 0, both flags <= 0, and RAS storage pointer <= 0.
- stall: pc, RAS and ras_count are held. Flags are 0. call/ret are ignored, with no push or pop.
- Sequential: pc <= (pc + STEP) mod 2^PC_W; the result wraps silently.
- jmp: pc <= pc_jmp. Taken branch: pc <= pc_branch. The RAS is untouched in both cases.
- call (ret=0): pc <= pc_jmp and push (pc+STEP) mod 2^PC_W.
  - If ras_count < RAS_DEPTH, ras_count increments.
  - If the stack is full, the write overwrites the oldest slot (circular buffer), ras_count stays RAS_DEPTH, and ras_overflow pulses.
- ret (call=0), stack not empty: pc <= top entry, then pop, so ras_count decrements.
- ret with empty stack: pc <= pc_jmp, ras_count stays 0, and ras_underflow pulses.
- call and ret together (coroutine swap): pc <= top entry, and the top is replaced with pc+STEP. ras_count is unchanged and no flag is raised.
  - If the stack is empty: pc <= pc_jmp, push pc+STEP (ras_count becomes 1), and ras_underflow pulses.
- Any mix of ret/call with jmp or branch: ret/call wins, and the losing requests are dropped.

## Timing
- One-cycle latency: controls sampled on edge N produce the new pc after edge N.
- ras_count and both flags are registered and update on the same edge as pc.
- Each flag is high for exactly one cycle per event. Repeated events in consecutive cycles keep the flag high.
- The RAS read is combinational from the current top pointer. There is no bypass: a ret issued in the cycle after a call returns the just-pushed address, because the push has already been committed.
- Reset asserted mid-sequence discards all RAS contents on that edge.

## Configuration
- FETCH_RAS_EN defined: the RAS is built and call/ret behave as above.
- FETCH_RAS_EN undefined: no RAS storage is built.
  - call and ret each behave as jmp (pc <= pc_jmp) at their priority level.
  - ras_count, ras_overflow and ras_underflow are tied to 0.
  - Ports are identical in both builds.

## Test plan
- Reset, then 3 free-running cycles with PC_W=10, STEP=1 -> pc = 0, 1, 2, 3. Force pc to 1023 via jmp with pc_jmp=1023, then one sequential cycle -> pc = 0.
- From pc=5, stall=1 together with jmp=1, pc_jmp=40 -> pc stays 5 and ras_count is unchanged. Release stall -> pc = 40.
- From pc=10, call with pc_jmp=100 -> pc=100, ras_count=1. Then ret -> pc=11, ras_count=0.
- With RAS_DEPTH=4, perform 5 calls from pcs 0, 10, 20, 30, 40 -> ras_overflow pulses on the 5th only. Then 4 rets -> pc = 41, 31, 21, 11.
- ret with empty stack and pc_jmp=77 -> pc=77, ras_underflow high for 1 cycle, ras_count=0.
- From pc=50 with top entry 9, assert call, ret and jmp together -> pc=9, top becomes 51, ras_count unchanged. In a build without FETCH_RAS_EN, the same stimulus -> pc=pc_jmp.

Source files
------------

// File: rtl/fetch_pc_ras.sv
// fetch_pc_ras: fetch-stage PC generator with optional return-address stack, enabled by defining FETCH_RAS_EN
module fetch_pc_ras #(
  parameter int PC_W      = 10,
  parameter int STEP      = 1,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch,
  input  logic                           alu_zero,
  input  logic [PC_W-1:0]                pc_branch,
  input  logic                           jmp,
  input  logic                           call,
  input  logic                           ret,
  input  logic [PC_W-1:0]                pc_jmp,
  output logic [PC_W-1:0]                pc,
  output logic [$clog2(RAS_DEPTH+1)-1:0] ras_count,
  output logic                           ras_overflow,
  output logic                           ras_underflow
);
  localparam logic [PC_W-1:0] STEP_V = PC_W'(STEP);
  localparam logic [PC_W-1:0] RST_V  = PC_W'(RESET_PC);
  logic [PC_W-1:0] w_seq, w_next;
  assign w_seq = pc + STEP_V;
  // pc register: reset vector, hold on stall, otherwise take the selected next pc
  always_ff @(posedge clk)
    if (reset) pc <= RST_V;
    else if (!stall) pc <= w_next;
`ifdef FETCH_RAS_EN
  localparam int CW = $clog2(RAS_DEPTH+1);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [CW-1:0] FULL_C = CW'(RAS_DEPTH);
  localparam logic [PW-1:0] LAST_P = PW'(RAS_DEPTH-1);
  logic [PC_W-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0]   r_ptr, w_ptr_inc, w_ptr_dec;
  logic [CW-1:0]   r_count;
  logic            r_ovf, r_unf, w_empty, w_full, w_push, w_swap, w_pop;
  // r_ptr is the next write slot of a circular buffer, so the top lives one slot behind it
  always_comb begin
    w_ptr_inc = (r_ptr == LAST_P) ? '0 : r_ptr + PW'(1);
    w_ptr_dec = (r_ptr == '0) ? LAST_P : r_ptr - PW'(1);
    w_empty   = r_count == '0;
    w_full    = r_count == FULL_C;
    w_push    = call & (~ret | w_empty);
    w_swap    = call & ret & ~w_empty;
    w_pop     = ret & ~call & ~w_empty;
    w_next    = ret ? (w_empty ? pc_jmp : r_ras[w_ptr_dec])
              : (call | jmp) ? pc_jmp
              : (branch & alu_zero) ? pc_branch : w_seq;
  end
  // return-address storage: push writes the next slot, a call+ret swap rewrites the top in place
  always_ff @(posedge clk)
    if (!reset && !stall && (w_push || w_swap)) r_ras[w_swap ? w_ptr_dec : r_ptr] <= w_seq;
  // stack pointer, occupancy and one-cycle event flags
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr   <= '0;
      r_count <= '0;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
    end else if (stall) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= call & ~ret & w_full;
      r_unf <= ret & w_empty;
      if (w_push) r_ptr <= w_ptr_inc;
      else if (w_pop) r_ptr <= w_ptr_dec;
      if (w_push && !w_full) r_count <= r_count + CW'(1);
      else if (w_pop) r_count <= r_count - CW'(1);
    end
  end
  assign ras_count     = r_count;
  assign ras_overflow  = r_ovf;
  assign ras_underflow = r_unf;
`else
  // without a stack, call and ret are plain jumps to pc_jmp
  always_comb w_next = (ret | call | jmp) ? pc_jmp : (branch & alu_zero) ? pc_branch : w_seq;
  assign ras_count     = '0;
  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_pc_ras.sv
// tb_fetch_pc_ras: scoreboard bench for fetch_pc_ras with a queue-based reference model
module tb_fetch_pc_ras;
  localparam int PC_W = 10;
  localparam int STEP = 1;
  localparam int RESET_PC = 0;
  localparam int RAS_DEPTH = 4;
  localparam int CW = $clog2(RAS_DEPTH+1);

  logic clk = 0, reset = 0, stall = 0, branch = 0, alu_zero = 0, jmp = 0, call = 0, ret = 0;
  logic [PC_W-1:0] pc_branch = '0, pc_jmp = '0, pc;
  logic [CW-1:0] ras_count;
  logic ras_overflow, ras_underflow;

  fetch_pc_ras #(.PC_W(PC_W), .STEP(STEP), .RESET_PC(RESET_PC), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clk(clk), .reset(reset), .stall(stall), .branch(branch), .alu_zero(alu_zero),
    .pc_branch(pc_branch), .jmp(jmp), .call(call), .ret(ret), .pc_jmp(pc_jmp),
    .pc(pc), .ras_count(ras_count), .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  typedef struct {int pc; int cnt; bit ov; bit un;} exp_t;
  exp_t exp_q[$];
  int ras[$];
  int m_pc = 0;
  int checks = 0, failures = 0;
  bit done = 0;

  // apply one cycle of controls and predict the state after the next rising edge
  task automatic cyc(input bit rs, st, br, z, jp, cl, rt, input int pb, pj);
    int seq, nxt;
    bit ov, un;
    @(negedge clk);
    reset = rs; stall = st; branch = br; alu_zero = z; jmp = jp; call = cl; ret = rt;
    pc_branch = pb[PC_W-1:0]; pc_jmp = pj[PC_W-1:0];
    ov = 0; un = 0;
    seq = (m_pc + STEP) % (1 << PC_W);
    if (rs) begin
      m_pc = RESET_PC;
      ras.delete();
    end else if (!st) begin
      nxt = jp ? pj : (br && z) ? pb : seq;
`ifdef FETCH_RAS_EN
      if (rt && cl) begin
        if (ras.size() == 0) begin nxt = pj; ras.push_back(seq); un = 1; end
        else begin nxt = ras[$]; ras[$] = seq; end
      end else if (rt) begin
        if (ras.size() == 0) begin nxt = pj; un = 1; end
        else nxt = ras.pop_back();
      end else if (cl) begin
        nxt = pj;
        ras.push_back(seq);
        if (ras.size() > RAS_DEPTH) begin void'(ras.pop_front()); ov = 1; end
      end
`else
      if (rt || cl) nxt = pj;
`endif
      m_pc = nxt;
    end
    exp_q.push_back('{m_pc, ras.size(), ov, un});
  endtask

  // monitor: compare DUT state against the oldest prediction once per cycle
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        checks += 4;
        if (pc !== e.pc[PC_W-1:0]) begin failures++; $display("FAIL pc t=%0t got=%0d exp=%0d", $time, pc, e.pc); end
        if (ras_count !== e.cnt[CW-1:0]) begin failures++; $display("FAIL ras_count t=%0t got=%0d exp=%0d", $time, ras_count, e.cnt); end
        if (ras_overflow !== e.ov) begin failures++; $display("FAIL ras_overflow t=%0t got=%0b exp=%0b", $time, ras_overflow, e.ov); end
        if (ras_underflow !== e.un) begin failures++; $display("FAIL ras_underflow t=%0t got=%0b exp=%0b", $time, ras_underflow, e.un); end
      end
    end
  end

  initial begin
    cyc(1,0,0,0,0,0,0,0,0);
    repeat (3) cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,1023);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,5);
    cyc(0,1,0,0,1,0,0,0,40);
    cyc(0,0,0,0,1,0,0,0,40);
    cyc(0,0,0,0,1,0,0,0,10);
    cyc(0,0,0,0,0,1,0,0,100);
    cyc(0,0,0,0,0,0,1,0,0);
    cyc(0,0,0,0,1,0,0,0,0);
    for (int i = 1; i <= 4; i++) cyc(0,0,0,0,0,1,0,0,10*i);
    cyc(0,0,0,0,0,1,0,0,99);
    repeat (4) cyc(0,0,0,0,0,0,1,0,0);
    cyc(0,0,0,0,0,0,1,0,77);
    cyc(0,0,0,0,0,0,1,0,78);
    cyc(0,0,0,0,0,0,0,0,0);
    cyc(0,0,0,0,1,0,0,0,8);
    cyc(0,0,0,0,0,1,0,0,50);
    cyc(0,0,0,0,1,1,1,0,200);
    cyc(0,0,0,0,0,0,1,0,300);
    cyc(0,0,1,1,0,0,0,600,0);
    cyc(0,0,1,0,0,0,0,700,0);
    cyc(0,1,0,0,0,1,1,0,33);
    cyc(1,0,0,0,0,1,0,0,44);
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0,99) < 2, $urandom_range(0,99) < 15, $urandom_range(0,99) < 40,
          $urandom_range(0,1), $urandom_range(0,99) < 20, $urandom_range(0,99) < 30,
          $urandom_range(0,99) < 30, $urandom_range(0,1023), $urandom_range(0,1023));
    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin failures++; $display("FAIL drain left=%0d exp=0", exp_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
